// File: rtl/design_22.sv
// design_22: one-cycle registered adder with a start/valid strobe.
// DESIGN_22_SAT_EN selects a saturating sum and adds the ovf output.
module design_22 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef DESIGN_22_SAT_EN
  output logic         ovf,
`endif
  output logic [W-1:0] y,
  output logic         valid
);

  logic [W:0]   sum_full;
  logic         carry;
  logic [W-1:0] sum;

  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  assign sum_full = {1'b0, a} + {1'b0, b};
  assign carry    = sum_full[W];

`ifdef DESIGN_22_SAT_EN
  assign sum = carry ? {W{1'b1}} : sum_full[W-1:0];
`else
  assign sum = sum_full[W-1:0];
`endif

  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    if (start) begin
      y_d     = sum;
      valid_d = 1'b1;
      ovf_d   = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

`ifdef DESIGN_22_SAT_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_design_22.sv
// tb_design_22: directed + random checks of design_22 against
// an arithmetic reference model of the registered adder.
module tb_design_22;

  localparam int W = 12;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] y;
  logic         valid;
`ifdef DESIGN_22_SAT_EN
  logic         ovf;
`endif

  int total = 0;
  int passed = 0;

  int m_y = 0;
  int m_v = 0;
  int m_o = 0;

  design_22 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef DESIGN_22_SAT_EN
    .ovf   (ovf),
`endif
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, int'(valid), m_v);
    chk({tag, ".y"}, int'(y), m_y);
`ifdef DESIGN_22_SAT_EN
    chk({tag, ".ovf"}, int'(ovf), m_o);
`endif
  endtask

  // Model: integer sum, then wrap or clamp at 2^W.
  task automatic model_edge(input int s, input int aa, input int bb);
    int t;
    if (rst_n !== 1'b1) begin
      m_y = 0; m_v = 0; m_o = 0;
      return;
    end
    if (s != 0) begin
      t = aa + bb;
`ifdef DESIGN_22_SAT_EN
      m_o = (t > MAXV) ? 1 : 0;
      m_y = (t > MAXV) ? MAXV : t;
`else
      m_o = 0;
      m_y = t % (MAXV + 1);
`endif
      m_v = 1;
    end else begin
      m_v = 0;
      m_o = 0;
    end
  endtask

  task automatic cyc(input int s, input int aa, input int bb,
                     input string tag);
    start = s[0];
    a = aa[W-1:0];
    b = bb[W-1:0];
    @(posedge clk);
    model_edge(s, aa, bb);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int ra, rb;
    rst_n = 1'b0;
    start = 1'b1;
    a = 12'd5;
    b = 12'd7;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst.valid", int'(valid), 0);
      chk("rst.y", int'(y), 0);
    end
    rst_n = 1'b1;
    start = 1'b0;

    cyc(1, 'h123, 'h0F0, "single");
    chk("single.const", int'(y), 'h213);
    cyc(0, 0, 0, "single.idle");
    chk("single.hold", int'(y), 'h213);

    for (int i = 0; i < 10; i++) begin
      ra = int'($urandom_range(0, 1023));
      rb = int'($urandom_range(0, 1023));
      cyc(1, ra, rb, "sweep.op");
      cyc(0, 0, 0, "sweep.idle1");
      cyc(0, 0, 0, "sweep.idle2");
    end

    cyc(1, 1, 2, "b2b.0");
    chk("b2b.0c", int'(y), 'h003);
    cyc(1, 3, 4, "b2b.1");
    chk("b2b.1c", int'(y), 'h007);
    cyc(1, 'h7FF, 'h001, "b2b.2");
    chk("b2b.2c", int'(y), 'h800);
    cyc(0, 0, 0, "b2b.idle");

    cyc(1, 'hFFF, 'h002, "wrap");
`ifdef DESIGN_22_SAT_EN
    chk("wrap.c", int'(y), 'hFFF);
    chk("wrap.ovf", int'(ovf), 1);
`else
    chk("wrap.c", int'(y), 'h001);
`endif
    cyc(1, 'hFFF, 'h001, "wrap.edge");
    cyc(0, 0, 0, "wrap.idle");

    for (int i = 0; i < 8; i++) begin
      ra = int'($urandom_range(0, MAXV));
      rb = int'($urandom_range(0, MAXV));
      cyc(1, ra, rb, "full.op");
    end
    cyc(0, 0, 0, "full.idle");

    // Asynchronous clear between edges.
    cyc(1, 'h456, 'h111, "async.pre");
    #2;
    rst_n = 1'b0;
    #1;
    m_y = 0; m_v = 0; m_o = 0;
    chk("async.valid", int'(valid), 0);
    chk("async.y", int'(y), 0);
    cyc(1, 'h0AA, 'h055, "async.hold");
    rst_n = 1'b1;

    // Start sampled, reset drops before the next edge.
    start = 1'b1;
    a = 12'h321;
    b = 12'h010;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    model_edge(1, 'h321, 'h010);
    #1;
    chk_all("midop.inrst");
    rst_n = 1'b1;
    start = 1'b0;
    cyc(0, 0, 0, "midop.idle");
    cyc(1, 'h200, 'h034, "midop.fresh");
    chk("midop.const", int'(y), 'h234);
    cyc(0, 0, 0, "midop.end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
